fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch stage between instr_mem and the Core decode stage.
- Drives the fetch address into instr_mem, captures each returned instruction word with its PC, and buffers them in a small FIFO.
- Hands instructions downstream with a valid/ready handshake.
- Flushes and restarts fetch on a branch/jump redirect from the execute stage.

Parameters:
- XLEN, 32, width of PC and instruction words.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- redirect_valid  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  XLEN  new fetch target; bits [1:0] ignored and treated as 0.
- imem_addr  output  XLEN  address to instr_mem.
- imem_rdata  input  XLEN  instr_mem data; valid one cycle after the address is sampled.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head when out_valid && out_ready.
- out_instr  output  XLEN  head instruction.
- out_pc  output  XLEN  PC of head instruction.
- fq_count  output  $clog2(DEPTH)+1  number of valid FIFO entries.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC; pending=0; count=0; read and write pointers=0; storage=0.
  - out_valid=0, out_instr=0, out_pc=0, fq_count=0.
- imem_addr is combinationally equal to fetch_pc at all times.
- Issue:
  - occupancy = count + pending.
  - issue = !redirect_valid && (occupancy < DEPTH || (occupancy == DEPTH && pop)).
  - pop = out_valid && out_ready.
  - On issue: pending<=1, pending_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps modulo 2^XLEN).
  - Without issue: pending<=0 and fetch_pc is held.
- Capture: in any cycle with pending=1 and no redirect_valid, {imem_rdata, pending_pc} is written at the write pointer, and the write pointer advances.
- Output:
  - out_valid = (count != 0) && !redirect_valid.
  - out_instr and out_pc are driven from the read-pointer entry.
  - On pop the read pointer advances.
- Count: count updates by +push -pop. Simultaneous push and pop leaves count unchanged.
- Pointers wrap modulo DEPTH.
- Latency:
  - First edge after reset release issues RESET_PC.
  - Second edge captures it; out_valid=1 after the second edge.
  - Steady-state throughput is 1 instruction per cycle while out_ready=1.
- Full: push into a full FIFO cannot occur, because issue is credit-gated. Issue resumes in the same cycle as a pop when occupancy==DEPTH.
- Empty: out_valid=0; out_ready is ignored.
- Redirect (highest priority, cycle t):
  - out_valid forced 0 in cycle t; no pop.
  - On the edge: count<=0, both pointers<=0, pending<=0 (the in-flight response is discarded), fetch_pc<={redirect_pc[XLEN-1:2],2'b00}.
  - No issue in cycle t.
  - Cycle t+1: imem_addr=redirect_pc and issue proceeds normally; first redirected instruction appears at out after the edge ending cycle t+2.
- Back-to-back redirects: each redirect overrides the previous one; only the last target is fetched.
- Reset asserted mid-operation: all state clears immediately and the FIFO contents are lost. Fetch restarts at RESET_PC after release.

Test Plan:
- Reset release, imem holds word k at address 4k, out_ready=1 -> out_valid rises after the 2nd edge; out_pc sequence 0,4,8,12,... with one instruction per cycle; out_instr matches memory.
- out_ready=0 for 10 cycles after start -> fq_count saturates at 4; imem_addr stops at 0x10; no entry overwritten. Raising out_ready -> PCs 0,4,8,12,16 delivered without loss or duplication.
- Redirect to 0x100 while 3 entries are buffered and one is pending -> out_valid=0 that cycle and the next. Next delivered out_pc=0x100 then 0x104; no stale PC from before the redirect appears.
- redirect_pc=0x203 -> fetch restarts at 0x200.
- Redirects in two consecutive cycles to 0x40 then 0x80 -> the first delivered PC is 0x80.
- reset pulsed low between edges while fq_count=2 -> outputs 0 immediately. After release the sequence restarts at RESET_PC; with a RESET_PC=32'hFFFF_FFFC override the PCs wrap to 0x0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundle of the fetch-queue signals.
//   redirect_valid / redirect_pc : flush and restart request from execute
//   imem_addr / imem_rdata       : instr_mem address out, data back one cycle later
//   out_valid / out_ready        : head-of-queue handshake towards decode
//   out_instr / out_pc           : head instruction and its PC
//   fq_count                     : number of buffered entries
// master = the fetch queue itself, slave = its environment.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                     redirect_valid;
  logic [XLEN-1:0]          redirect_pc;
  logic [XLEN-1:0]          imem_addr;
  logic [XLEN-1:0]          imem_rdata;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_instr;
  logic [XLEN-1:0]          out_pc;
  logic [$clog2(DEPTH):0]   fq_count;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, fq_count
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, fq_count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch stage between instr_mem and decode.
// Drives the fetch PC to instr_mem, captures each returned word together
// with its PC into a small FIFO and presents the head with valid/ready.
// A redirect flushes everything and restarts fetch at the new target.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : fetch_queue_if.master (redirect, imem, output handshake, count)
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);
  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  logic [XLEN-1:0] fetch_pc_p0;
  logic            vld_p1;
  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] fifo_instr [DEPTH];
  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   occupancy;
  logic            pop;
  logic            push;
  logic            issue;

  // Occupancy counts the in-flight request as a reserved slot, so an issued
  // fetch always has room when its data returns (credit-based issue).
  assign occupancy = count + CW'(vld_p1);
  assign pop       = bus.out_valid && bus.out_ready;
  assign push      = vld_p1 && !bus.redirect_valid;
  assign issue     = !bus.redirect_valid &&
                     ((occupancy < DEPTH_C) || ((occupancy == DEPTH_C) && pop));

  assign bus.imem_addr = fetch_pc_p0;
  assign bus.out_valid = (count != '0) && !bus.redirect_valid;
  assign bus.out_instr = fifo_instr[rd_ptr];
  assign bus.out_pc    = fifo_pc[rd_ptr];
  assign bus.fq_count  = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_p0 <= RESET_PC;
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (bus.redirect_valid) begin
      // Flush: the in-flight response is dropped by clearing vld_p1.
      fetch_pc_p0 <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      vld_p1      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      // p0 -> p1: address issued to instr_mem this edge
      vld_p1 <= issue;
      if (issue) begin
        pc_p1       <= fetch_pc_p0;
        fetch_pc_p0 <= fetch_pc_p0 + XLEN'(4);
      end
      // p1 -> FIFO: instr_mem data for pc_p1 is on imem_rdata now
      if (push) begin
        fifo_instr[wr_ptr] <= bus.imem_rdata;
        fifo_pc[wr_ptr]    <= pc_p1;
        wr_ptr             <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus2 ();

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );
  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(rst_n), .bus(bus2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC3A5_0F1E;
  endfunction

  // synchronous instruction memory: data one cycle after the address
  always @(posedge clk) begin
    bus.imem_rdata  <= mem_word(bus.imem_addr);
    bus2.imem_rdata <= mem_word(bus2.imem_addr);
  end

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: FIFO of buffered PCs, one optional in-flight fetch, next PC
  logic [31:0] m_q [$];
  bit          m_inf_v;
  logic [31:0] m_inf_pc;
  logic [31:0] m_fetch;

  bit          cur_redir;
  bit          cur_ready;
  logic [31:0] cur_rpc;
  bit          exp_valid;
  logic [31:0] exp_pc, exp_instr, exp_addr;
  logic [2:0]  exp_cnt;
  logic [31:0] got [$];

  task automatic model_reset();
    m_q.delete();
    m_inf_v  = 1'b0;
    m_inf_pc = '0;
    m_fetch  = 32'h0;
  endtask

  task automatic model_edge(input bit redir, input logic [31:0] rpc, input bit ready);
    bit pop, issue;
    int occ;
    pop = (m_q.size() != 0) && !redir && ready;
    if (redir) begin
      m_q.delete();
      m_inf_v = 1'b0;
      m_fetch = rpc & 32'hFFFF_FFFC;
    end else begin
      occ   = m_q.size() + int'(m_inf_v);
      issue = (occ < DEPTH) || (occ == DEPTH && pop);
      if (pop) void'(m_q.pop_front());
      if (m_inf_v) m_q.push_back(m_inf_pc);
      m_inf_v = issue;
      if (issue) begin
        m_inf_pc = m_fetch;
        m_fetch  = m_fetch + 32'd4;
      end
    end
  endtask

  // called at a falling edge; sets inputs and derives the expected outputs
  task automatic drive(input bit redir, input logic [31:0] rpc, input bit ready);
    cur_redir = redir;
    cur_rpc   = rpc;
    cur_ready = ready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.out_ready      = ready;
    #1;
    exp_valid = (m_q.size() != 0) && !redir;
    exp_pc    = (m_q.size() != 0) ? m_q[0] : 32'h0;
    exp_instr = mem_word(exp_pc);
    exp_cnt   = 3'(m_q.size());
    exp_addr  = m_fetch;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(cur_redir, cur_rpc, cur_ready);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.out_ready       = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = '0;
    bus2.out_ready      = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.fq_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got v=%0b n=%0d, want v=0 n=0", bus.out_valid, bus.fq_count);
    end
    n_tests++;
    if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0 || bus.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got pc=%h i=%h a=%h, want all 0", bus.out_pc, bus.out_instr, bus.imem_addr);
    end
    n_tests++;
    if (bus2.imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL reset_pc_override: got a=%h, want fffffffc", bus2.imem_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    apply_reset();
    for (int c = 0; c < 14; c++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_tests++;
      if (bus.out_valid !== exp_valid || bus.fq_count !== exp_cnt || bus.imem_addr !== exp_addr ||
          (exp_valid && (bus.out_pc !== exp_pc || bus.out_instr !== exp_instr))) begin
        n_fail++;
        $display("FAIL stream c%0d: got v=%0b n=%0d a=%h pc=%h i=%h, want v=%0b n=%0d a=%h pc=%h i=%h",
                 c, bus.out_valid, bus.fq_count, bus.imem_addr, bus.out_pc, bus.out_instr,
                 exp_valid, exp_cnt, exp_addr, exp_pc, exp_instr);
      end
      if (c == 2 || c == 5) begin
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * (c - 2))) begin
          n_fail++;
          $display("FAIL stream_latency c%0d: got v=%0b pc=%h, want v=1 pc=%h", c, bus.out_valid, bus.out_pc, 32'(4 * (c - 2)));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 32'h0, 1'b0);
      n_tests++;
      if (bus.out_valid !== exp_valid || bus.fq_count !== exp_cnt || bus.imem_addr !== exp_addr ||
          (exp_valid && (bus.out_pc !== exp_pc || bus.out_instr !== exp_instr))) begin
        n_fail++;
        $display("FAIL backpressure c%0d: got v=%0b n=%0d a=%h pc=%h, want v=%0b n=%0d a=%h pc=%h",
                 c, bus.out_valid, bus.fq_count, bus.imem_addr, bus.out_pc, exp_valid, exp_cnt, exp_addr, exp_pc);
      end
      tick();
    end
    #1;
    n_tests++;
    if (bus.fq_count !== 3'd4 || bus.imem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL backpressure_full: got n=%0d a=%h, want n=4 a=00000010", bus.fq_count, bus.imem_addr);
    end
    got.delete();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_tests++;
      if (bus.out_valid !== exp_valid || bus.fq_count !== exp_cnt || bus.imem_addr !== exp_addr ||
          (exp_valid && (bus.out_pc !== exp_pc || bus.out_instr !== exp_instr))) begin
        n_fail++;
        $display("FAIL backpressure_drain c%0d: got v=%0b n=%0d a=%h pc=%h, want v=%0b n=%0d a=%h pc=%h",
                 c, bus.out_valid, bus.fq_count, bus.imem_addr, bus.out_pc, exp_valid, exp_cnt, exp_addr, exp_pc);
      end
      if (bus.out_valid) got.push_back(bus.out_pc);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (got.size() <= k || got[k] !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL backpressure_order k%0d: got %h (n=%0d), want %h", k,
                 (got.size() > k) ? got[k] : 32'hx, got.size(), 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 32'h0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h100, 1'b1);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.fq_count !== 3'd3) begin
      n_fail++;
      $display("FAIL redirect_cycle: got v=%0b n=%0d, want v=0 n=3", bus.out_valid, bus.fq_count);
    end
    tick();
    got.delete();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_tests++;
      if (bus.out_valid !== exp_valid || bus.fq_count !== exp_cnt || bus.imem_addr !== exp_addr ||
          (exp_valid && (bus.out_pc !== exp_pc || bus.out_instr !== exp_instr))) begin
        n_fail++;
        $display("FAIL redirect c%0d: got v=%0b n=%0d a=%h pc=%h, want v=%0b n=%0d a=%h pc=%h",
                 c, bus.out_valid, bus.fq_count, bus.imem_addr, bus.out_pc, exp_valid, exp_cnt, exp_addr, exp_pc);
      end
      if (bus.out_valid) got.push_back(bus.out_pc);
      tick();
    end
    n_tests++;
    if (got.size() < 2 || got[0] !== 32'h100 || got[1] !== 32'h104) begin
      n_fail++;
      $display("FAIL redirect_target: got first=%h second=%h (n=%0d), want 00000100 00000104",
               (got.size() > 0) ? got[0] : 32'hx, (got.size() > 1) ? got[1] : 32'hx, got.size());
    end
    // unaligned target
    drive(1'b1, 32'h203, 1'b1);
    tick();
    got.delete();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 32'h0, 1'b1);
      if (bus.out_valid) got.push_back(bus.out_pc);
      tick();
    end
    n_tests++;
    if (got.size() < 1 || got[0] !== 32'h200) begin
      n_fail++;
      $display("FAIL redirect_align: got %h (n=%0d), want 00000200", (got.size() > 0) ? got[0] : 32'hx, got.size());
    end
    // back-to-back redirects
    drive(1'b1, 32'h40, 1'b1);
    tick();
    drive(1'b1, 32'h80, 1'b1);
    tick();
    got.delete();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_tests++;
      if (bus.out_valid !== exp_valid || bus.fq_count !== exp_cnt || bus.imem_addr !== exp_addr ||
          (exp_valid && (bus.out_pc !== exp_pc || bus.out_instr !== exp_instr))) begin
        n_fail++;
        $display("FAIL redirect_b2b c%0d: got v=%0b n=%0d a=%h pc=%h, want v=%0b n=%0d a=%h pc=%h",
                 c, bus.out_valid, bus.fq_count, bus.imem_addr, bus.out_pc, exp_valid, exp_cnt, exp_addr, exp_pc);
      end
      if (bus.out_valid) got.push_back(bus.out_pc);
      tick();
    end
    n_tests++;
    if (got.size() < 1 || got[0] !== 32'h80) begin
      n_fail++;
      $display("FAIL redirect_b2b_first: got %h (n=%0d), want 00000080", (got.size() > 0) ? got[0] : 32'hx, got.size());
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(15) == 0), $urandom, ($urandom_range(3) != 0));
      n_tests++;
      if (bus.out_valid !== exp_valid || bus.fq_count !== exp_cnt || bus.imem_addr !== exp_addr ||
          (exp_valid && (bus.out_pc !== exp_pc || bus.out_instr !== exp_instr))) begin
        n_fail++;
        $display("FAIL random c%0d: got v=%0b n=%0d a=%h pc=%h i=%h, want v=%0b n=%0d a=%h pc=%h i=%h",
                 c, bus.out_valid, bus.fq_count, bus.imem_addr, bus.out_pc, bus.out_instr,
                 exp_valid, exp_cnt, exp_addr, exp_pc, exp_instr);
      end
      tick();
    end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 32'h0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b1);
    n_tests++;
    if (bus.fq_count !== 3'd2 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_pre: got n=%0d v=%0b, want n=2 v=1", bus.fq_count, bus.out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.fq_count !== 3'd0 || bus.out_pc !== 32'h0 ||
        bus.out_instr !== 32'h0 || bus.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL midop_async: got v=%0b n=%0d pc=%h i=%h a=%h, want all 0",
               bus.out_valid, bus.fq_count, bus.out_pc, bus.out_instr, bus.imem_addr);
    end
    #1 rst_n = 1'b1;
    model_reset();
    tick();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_tests++;
      if (bus.out_valid !== exp_valid || bus.fq_count !== exp_cnt || bus.imem_addr !== exp_addr ||
          (exp_valid && (bus.out_pc !== exp_pc || bus.out_instr !== exp_instr))) begin
        n_fail++;
        $display("FAIL midop_restart c%0d: got v=%0b n=%0d a=%h pc=%h, want v=%0b n=%0d a=%h pc=%h",
                 c, bus.out_valid, bus.fq_count, bus.imem_addr, bus.out_pc, exp_valid, exp_cnt, exp_addr, exp_pc);
      end
      tick();
    end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] wpc;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      #1;
      wpc = 32'hFFFF_FFFC + 32'(4 * (k - 2));
      n_tests++;
      if (k < 2) begin
        if (bus2.out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL wrap_latency k%0d: got v=%0b, want v=0", k, bus2.out_valid);
        end
      end else if (bus2.out_valid !== 1'b1 || bus2.out_pc !== wpc || bus2.out_instr !== mem_word(wpc)) begin
        n_fail++;
        $display("FAIL wrap k%0d: got v=%0b pc=%h i=%h, want v=1 pc=%h i=%h",
                 k, bus2.out_valid, bus2.out_pc, bus2.out_instr, wpc, mem_word(wpc));
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_random();
    test_reset_midop();
    test_pc_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
